// File: rtl/elevator_req_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Shared level/occupancy width helpers and defaults for the
//            elevator request queue.
// Revision : 1.0
// ============================================================================
package elevator_pkg;

    localparam int NUM_LVLS_DEF = 4;
    localparam int DEPTH_DEF    = 4;

    function automatic int lvl_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

    localparam int LVL_W_DEF = lvl_w(NUM_LVLS_DEF);

    typedef logic [LVL_W_DEF-1:0] lvl_t;

endpackage
`default_nettype wire

// File: rtl/elevator_req_queue_lvl_match.sv
`default_nettype none
// ============================================================================
// Module   : lvl_match_vec
// Purpose  : Per-entry level match against the valid portion of a queue image.
// Revision : 1.0
// ============================================================================
module lvl_match_vec
    import elevator_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LVL_W = lvl_w(NUM_LVLS_DEF),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic [DEPTH-1:0][LVL_W-1:0] entries,
    input  logic [CNT_W-1:0]            count,
    input  logic [LVL_W-1:0]            lvl,
    output logic [DEPTH-1:0]            hit,
    output logic                        any_hit
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit[gi] = (CNT_W'(gi) < count) && (entries[gi] == lvl);
    end

    assign any_hit = |hit;

endmodule
`default_nettype wire

// File: rtl/elevator_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : elevator_req_queue
// Purpose  : Deduplicating floor-request FIFO with removal from any position.
// Revision : 1.0
// ============================================================================
module elevator_req_queue
    import elevator_pkg::*;
#(
    parameter int NUM_LVLS = NUM_LVLS_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LVL_W    = lvl_w(NUM_LVLS),
    parameter int CNT_W    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             press_valid,
    input  logic [LVL_W-1:0] press_lvl,
    input  logic             clr_valid,
    input  logic [LVL_W-1:0] clr_lvl,
    output logic             head_valid,
    output logic [LVL_W-1:0] head_lvl,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             press_ack,
    output logic             press_rej
);

    logic [DEPTH-1:0][LVL_W-1:0] r_entries;
    logic [CNT_W-1:0]            r_count;
    logic                        r_head_valid;
    logic                        r_full;
    logic                        r_ack;
    logic                        r_rej;

    logic [DEPTH-1:0][LVL_W-1:0] w_post;
    logic [DEPTH-1:0][LVL_W-1:0] w_next;
    logic [CNT_W-1:0]            w_post_count;
    logic [CNT_W-1:0]            w_next_count;
    logic [DEPTH-1:0]            w_clr_hit;
    logic [DEPTH-1:0]            w_dup_hit;
    logic [DEPTH-1:0]            w_shift;
    logic                        w_clr_any;
    logic                        w_dup_any;
    logic                        w_clr_in_range;
    logic                        w_press_in_range;
    logic                        w_clr_en;
    logic                        w_same_lvl;
    logic                        w_room;
    logic                        w_accept;

    // Widened compares keep the range test meaningful for any NUM_LVLS.
    assign w_clr_in_range   = (32'(clr_lvl)   < 32'(NUM_LVLS));
    assign w_press_in_range = (32'(press_lvl) < 32'(NUM_LVLS));

    lvl_match_vec #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_clr_match (
        .entries (r_entries),
        .count   (r_count),
        .lvl     (clr_lvl),
        .hit     (w_clr_hit),
        .any_hit (w_clr_any)
    );

    assign w_clr_en     = clr_valid & w_clr_in_range & w_clr_any;
    assign w_post_count = r_count - CNT_W'(w_clr_en);

    // Every slot at or above the cleared one pulls from its upper neighbour.
    always_comb begin
        logic w_seen;
        w_seen  = 1'b0;
        w_shift = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_seen     = w_seen | w_clr_hit[i];
            w_shift[i] = w_clr_en & w_seen;
        end
    end

    always_comb begin
        w_post = r_entries;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_shift[i]) begin
                w_post[i] = r_entries[i+1];
            end
        end
    end

    lvl_match_vec #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_dup_match (
        .entries (w_post),
        .count   (w_post_count),
        .lvl     (press_lvl),
        .hit     (w_dup_hit),
        .any_hit (w_dup_any)
    );

    assign w_same_lvl = clr_valid & (clr_lvl == press_lvl);
    assign w_room     = (w_post_count != CNT_W'(DEPTH));
    assign w_accept   = press_valid & w_press_in_range & ~w_same_lvl
                      & ~w_dup_any & w_room;

    always_comb begin
        w_next = w_post;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_accept && (CNT_W'(i) == w_post_count)) begin
                w_next[i] = press_lvl;
            end
        end
    end

    assign w_next_count = w_post_count + CNT_W'(w_accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entries    <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_full       <= 1'b0;
            r_ack        <= 1'b0;
            r_rej        <= 1'b0;
        end else begin
            r_entries    <= w_next;
            r_count      <= w_next_count;
            r_head_valid <= (w_next_count != '0);
            r_full       <= (w_next_count == CNT_W'(DEPTH));
            r_ack        <= w_accept;
            r_rej        <= press_valid & ~w_accept;
        end
    end

    a_count_range : assert property (@(posedge clk) disable iff (rst)
        r_count <= CNT_W'(DEPTH));

    assign head_valid = r_head_valid;
    assign head_lvl   = r_entries[0];
    assign count      = r_count;
    assign full       = r_full;
    assign press_ack  = r_ack;
    assign press_rej  = r_rej;

endmodule
`default_nettype wire

// File: tb/tb_elevator_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_req_queue
// Purpose  : Directed and randomized checks of elevator_req_queue against a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_elevator_req_queue;

    localparam int NL = 6;
    localparam int DP = 4;
    localparam int LW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          press_valid = 1'b0;
    logic [LW-1:0] press_lvl = '0;
    logic          clr_valid = 1'b0;
    logic [LW-1:0] clr_lvl = '0;
    logic          head_valid;
    logic [LW-1:0] head_lvl;
    logic [CW-1:0] count;
    logic          full;
    logic          press_ack;
    logic          press_rej;

    int checks = 0;
    int errors = 0;

    int q[$];
    bit exp_ack;
    bit exp_rej;

    elevator_req_queue #(
        .NUM_LVLS (NL),
        .DEPTH    (DP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .press_valid (press_valid),
        .press_lvl   (press_lvl),
        .clr_valid   (clr_valid),
        .clr_lvl     (clr_lvl),
        .head_valid  (head_valid),
        .head_lvl    (head_lvl),
        .count       (count),
        .full        (full),
        .press_ack   (press_ack),
        .press_rej   (press_rej)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Drive one cycle, advance the model, and return sampled #1 after the edge.
    task automatic tick(input bit pv, input int pl, input bit cv, input int cl);
        bit acc;
        int pl_trunc;
        int cl_trunc;
        pl_trunc    = pl % 8;
        cl_trunc    = cl % 8;
        press_valid = pv;
        press_lvl   = LW'(pl_trunc);
        clr_valid   = cv;
        clr_lvl     = LW'(cl_trunc);
        @(posedge clk);
        if (cv) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i] == cl_trunc) begin
                    q.delete(i);
                    break;
                end
            end
        end
        exp_ack = 1'b0;
        exp_rej = 1'b0;
        if (pv) begin
            acc = (pl_trunc < NL) && !(cv && cl_trunc == pl_trunc) && (q.size() < DP);
            foreach (q[i]) if (q[i] == pl_trunc) acc = 1'b0;
            if (acc) q.push_back(pl_trunc);
            exp_ack = acc;
            exp_rej = !acc;
        end
        #1;
        press_valid = 1'b0;
        clr_valid   = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (head_valid !== 1'b0 || head_lvl !== '0) begin errors++; $display("FAIL reset_head: got v=%0b l=%0d want 0/0", head_valid, head_lvl); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
        checks++; if (press_ack !== 1'b0 || press_rej !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ack=%0b rej=%0b want 0/0", press_ack, press_rej); end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_fill;
        int lv[3] = '{2, 0, 3};
        foreach (lv[i]) begin
            tick(1, lv[i], 0, 0);
            checks++; if (press_ack !== 1'b1 || press_rej !== 1'b0) begin errors++; $display("FAIL fill_ack%0d: got ack=%0b rej=%0b want 1/0", i, press_ack, press_rej); end
        end
        checks++; if (count !== 3'd3 || head_lvl !== 3'd2) begin errors++; $display("FAIL fill_state: got count=%0d head=%0d want 3/2", count, head_lvl); end
    endtask

    task automatic test_duplicate;
        tick(1, 0, 0, 0);
        checks++; if (press_rej !== 1'b1 || press_ack !== 1'b0) begin errors++; $display("FAIL dup_rej: got ack=%0b rej=%0b want 0/1", press_ack, press_rej); end
        checks++; if (count !== 3'd3 || head_lvl !== 3'd2) begin errors++; $display("FAIL dup_state: got count=%0d head=%0d want 3/2", count, head_lvl); end
    endtask

    task automatic test_clear;
        tick(0, 0, 1, 0);
        checks++; if (count !== 3'd2 || head_lvl !== 3'd2) begin errors++; $display("FAIL clr0: got count=%0d head=%0d want 2/2", count, head_lvl); end
        checks++; if (press_ack !== 1'b0 || press_rej !== 1'b0) begin errors++; $display("FAIL clr_pulses: got ack=%0b rej=%0b want 0/0", press_ack, press_rej); end
        tick(0, 0, 1, 2);
        checks++; if (count !== 3'd1 || head_lvl !== 3'd3) begin errors++; $display("FAIL clr2: got count=%0d head=%0d want 1/3", count, head_lvl); end
        tick(0, 0, 1, 5);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL clr_miss: got count=%0d want 1", count); end
        tick(0, 0, 1, 3);
        checks++; if (count !== 3'd0 || head_valid !== 1'b0) begin errors++; $display("FAIL clr_empty: got count=%0d v=%0b want 0/0", count, head_valid); end
    endtask

    task automatic test_full_clear_press;
        int lv[4] = '{1, 2, 3, 0};
        foreach (lv[i]) tick(1, lv[i], 0, 0);
        checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL full_set: got full=%0b count=%0d want 1/4", full, count); end
        tick(1, 1, 1, 2);
        checks++; if (press_rej !== 1'b1 || count !== 3'd3 || full !== 1'b0 || head_lvl !== 3'd1) begin errors++; $display("FAIL full_dup: got rej=%0b count=%0d full=%0b head=%0d want 1/3/0/1", press_rej, count, full, head_lvl); end
        tick(1, 2, 0, 0);
        tick(1, 2, 1, 2);
        checks++; if (press_rej !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL same_lvl: got rej=%0b count=%0d want 1/3", press_rej, count); end
        tick(1, 7, 0, 0);
        checks++; if (press_rej !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL range: got rej=%0b count=%0d want 1/3", press_rej, count); end
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 3);
        tick(0, 0, 1, 0);
        foreach (lv[i]) tick(1, lv[i], 0, 0);
        tick(1, 5, 1, 3);
        checks++; if (press_ack !== 1'b1 || full !== 1'b1 || count !== 3'd4 || head_lvl !== 3'd1) begin errors++; $display("FAIL full_swap: got ack=%0b full=%0b count=%0d head=%0d want 1/1/4/1", press_ack, full, count, head_lvl); end
        tick(0, 0, 1, 1);
        checks++; if (head_lvl !== 3'd2) begin errors++; $display("FAIL order1: got head=%0d want 2", head_lvl); end
        tick(0, 0, 1, 2);
        checks++; if (head_lvl !== 3'd0) begin errors++; $display("FAIL order2: got head=%0d want 0", head_lvl); end
        tick(0, 0, 1, 0);
        checks++; if (head_lvl !== 3'd5 || count !== 3'd1) begin errors++; $display("FAIL order3: got head=%0d count=%0d want 5/1", head_lvl, count); end
        tick(0, 0, 1, 5);
    endtask

    task automatic test_reset_mid;
        tick(1, 1, 0, 0);
        tick(1, 2, 0, 0);
        checks++; if (count !== 3'd2 || press_ack !== 1'b1) begin errors++; $display("FAIL pre_rst: got count=%0d ack=%0b want 2/1", count, press_ack); end
        press_valid = 1'b1;
        press_lvl   = 3'd3;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== '0 || head_valid !== 1'b0 || head_lvl !== '0 || full !== 1'b0 || press_ack !== 1'b0 || press_rej !== 1'b0) begin
            errors++; $display("FAIL rst_async: got count=%0d v=%0b head=%0d full=%0b ack=%0b rej=%0b want all 0", count, head_valid, head_lvl, full, press_ack, press_rej);
        end
        @(negedge clk);
        press_valid = 1'b0;
        rst = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        checks++; if (press_ack !== 1'b0 || press_rej !== 1'b0 || count !== '0) begin errors++; $display("FAIL rst_release: got ack=%0b rej=%0b count=%0d want 0/0/0", press_ack, press_rej, count); end
    endtask

    task automatic test_random;
        int pl;
        int cl;
        bit pv;
        bit cv;
        for (int n = 0; n < 600; n++) begin
            pv = ($urandom_range(0, 99) < 70);
            cv = ($urandom_range(0, 99) < 40);
            pl = $urandom_range(0, 7);
            if (q.size() > 0 && $urandom_range(0, 9) < 8)
                cl = q[$urandom_range(0, q.size() - 1)];
            else
                cl = $urandom_range(0, 7);
            if ($urandom_range(0, 19) == 0) cl = pl;
            tick(pv, pl, cv, cl);
            checks++;
            if (press_ack !== exp_ack || press_rej !== exp_rej || count !== CW'(q.size())
                || full !== (q.size() == DP) || head_valid !== (q.size() != 0)
                || (q.size() != 0 && head_lvl !== LW'(q[0]))) begin
                errors++;
                $display("FAIL random%0d: got ack=%0b rej=%0b count=%0d full=%0b v=%0b head=%0d want ack=%0b rej=%0b count=%0d head=%0d",
                         n, press_ack, press_rej, count, full, head_valid, head_lvl,
                         exp_ack, exp_rej, q.size(), (q.size() != 0) ? q[0] : 0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_duplicate;
        test_clear;
        test_full_clear_press;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
